// File: rtl/sequenciador_exibicao.sv
// Sequence playback engine: reads items from a sequence RAM and shows each on the LEDs, followed by a dark gap.
// Optional macro SEQ_FLASH_FINAL_EN adds an all-on flash after the last item.
module sequenciador_exibicao #(
   parameter int unsigned ON_CYCLES  = 3,
   parameter int unsigned OFF_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       abortar,
   input  logic [3:0] rodada,
   input  logic [3:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       ocupado,
   output logic       fim,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      LE      = 4'd1,
      ACESO   = 4'd2,
      APAGADO = 4'd3,
      FLASH   = 4'd4,
      FIM     = 4'd5
   } estado_t;

   localparam logic [15:0] ON_LAST  = 16'(ON_CYCLES - 1);
   localparam logic [15:0] OFF_LAST = 16'(OFF_CYCLES - 1);

   estado_t     estado, proximo;
   logic [15:0] contador;
   logic [3:0]  rodada_reg;
   logic [3:0]  item_reg;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO:  if (iniciar) proximo = LE;
         LE:      proximo = ACESO;
         ACESO:   if (contador == ON_LAST) proximo = APAGADO;
         APAGADO: begin
            if (contador == OFF_LAST) begin
               if (endereco == rodada_reg) begin
`ifdef SEQ_FLASH_FINAL_EN
                  proximo = FLASH;
`else
                  proximo = FIM;
`endif
               end else begin
                  proximo = LE;
               end
            end
         end
`ifdef SEQ_FLASH_FINAL_EN
         FLASH:   if (contador == ON_LAST) proximo = FIM;
`endif
         FIM:     proximo = OCIOSO;
         default: proximo = OCIOSO;
      endcase
      if (abortar && estado != OCIOSO) proximo = OCIOSO;
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado     <= OCIOSO;
         contador   <= '0;
         endereco   <= '0;
         rodada_reg <= '0;
         item_reg   <= '0;
      end else begin
         estado <= proximo;
         // Counter restarts on every state entry; idle holds it at zero.
         if (proximo != estado || estado == OCIOSO)
            contador <= '0;
         else
            contador <= contador + 16'd1;

         if (estado == OCIOSO && proximo == LE) begin
            rodada_reg <= rodada;
            endereco   <= '0;
         end
         if (estado == APAGADO && proximo == LE)
            endereco <= endereco + 4'd1;
         if (estado == LE && proximo == ACESO)
            item_reg <= dado_memoria;
      end
   end

   always_comb begin
      leds = 4'b0000;
      if (estado == ACESO) leds = item_reg;
`ifdef SEQ_FLASH_FINAL_EN
      if (estado == FLASH) leds = 4'b1111;
`endif
   end

   assign ocupado   = (estado != OCIOSO);
   assign fim       = (estado == FIM);
   assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Directed self-checking bench for sequenciador_exibicao (ON_CYCLES=3, OFF_CYCLES=2).
module tb_sequenciador_exibicao;

   logic       clock = 1'b0;
   logic       reset, iniciar, abortar;
   logic [3:0] rodada, dado_memoria, endereco, leds, db_estado;
   logic       ocupado, fim;
   logic [3:0] ram [16];
   int         total = 0;
   int         bad   = 0;

`ifdef SEQ_FLASH_FINAL_EN
   localparam int FLASH_LEN = 3;
`else
   localparam int FLASH_LEN = 0;
`endif

   sequenciador_exibicao #(.ON_CYCLES(3), .OFF_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
      .rodada(rodada), .dado_memoria(dado_memoria), .endereco(endereco),
      .leds(leds), .ocupado(ocupado), .fim(fim), .db_estado(db_estado)
   );

   always #5 clock = ~clock;
   assign dado_memoria = ram[endereco];

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Cycle c (c>=1) is the interval after the c-th edge following the start edge; sampled at negedge.
   task automatic play(input logic [3:0] rd, input bit chg, input int ac, input int rc, input int ncyc);
      int         last_end, fim_c, i, o;
      bit         stopped;
      logic [3:0] stop_addr, e_st, e_led, e_end;
      logic       e_oc, e_fim;
      last_end  = 6 * (int'(rd) + 1);
      fim_c     = last_end + FLASH_LEN + 1;
      stopped   = 1'b0;
      stop_addr = 4'd0;
      @(negedge clock);
      rodada  = rd;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         e_st = 4'd0; e_led = 4'd0; e_end = rd; e_oc = 1'b0; e_fim = 1'b0;
         if (stopped) begin
            e_end = stop_addr;
         end else if (c <= last_end) begin
            i = (c - 1) / 6;
            o = (c - 1) % 6;
            e_end = 4'(i);
            e_oc  = 1'b1;
            e_st  = (o == 0) ? 4'd1 : (o <= 3) ? 4'd2 : 4'd3;
            e_led = (o >= 1 && o <= 3) ? ram[i] : 4'd0;
         end else if (c < fim_c) begin
            e_st = 4'd4; e_led = 4'hF; e_oc = 1'b1;
         end else if (c == fim_c) begin
            e_st = 4'd5; e_oc = 1'b1; e_fim = 1'b1;
         end
         check($sformatf("leds rd%0d c%0d", rd, c), leds, e_led);
         check($sformatf("fim rd%0d c%0d", rd, c), {3'b0, fim}, {3'b0, e_fim});
         check($sformatf("ocupado rd%0d c%0d", rd, c), {3'b0, ocupado}, {3'b0, e_oc});
         check($sformatf("endereco rd%0d c%0d", rd, c), endereco, e_end);
         check($sformatf("db_estado rd%0d c%0d", rd, c), db_estado, e_st);
         if (c == ac) begin stopped = 1'b1; stop_addr = e_end; end
         if (c == rc) begin stopped = 1'b1; stop_addr = 4'd0; end
         iniciar = (c == 5) || (c == rc);
         abortar = (c == ac);
         reset   = (c == rc);
         if (chg && c == 3) rodada = 4'd5;
         @(negedge clock);
      end
      iniciar = 1'b0;
      abortar = 1'b0;
      reset   = 1'b0;
   endtask

   initial begin
      ram = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9,
              4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF, 4'h1};
      reset   = 1'b1;
      iniciar = 1'b1;
      abortar = 1'b0;
      rodada  = 4'd0;
      repeat (2) @(negedge clock);
      check("reset leds", leds, 4'd0);
      check("reset fim", {3'b0, fim}, 4'd0);
      check("reset ocupado", {3'b0, ocupado}, 4'd0);
      check("reset endereco", endereco, 4'd0);
      check("reset db_estado", db_estado, 4'd0);
      reset   = 1'b0;
      iniciar = 1'b0;

      // Three-item playback, with an ignored iniciar at cycle 5.
      play(4'd2, 1'b0, 0, 0, 24 + FLASH_LEN);
      // Single item; rodada changed mid-playback must not matter.
      play(4'd0, 1'b1, 0, 0, 12 + FLASH_LEN);
      // Abort during the second item; endereco holds 1, no fim.
      play(4'd2, 1'b0, 9, 0, 14);
      // Reset together with iniciar at cycle 12.
      play(4'd2, 1'b0, 0, 12, 16);
      // Full sixteen-item playback without address wrap.
      play(4'd15, 1'b0, 0, 0, 100 + FLASH_LEN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
